// File: rtl/flash_sdram_loader.sv
// Boot-image copier: streams ilen 16-bit words from parallel Flash (toggle req/ack) into SDRAM.
// Optional checksum output ocsum is enabled by defining FLASH_SDRAM_LOADER_CSUM_EN.
module flash_sdram_loader #(
  parameter int FL_AW      = 23,
  parameter int RAM_AW     = 24,
  parameter int LEN_W      = 23,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              istart,
  input  logic [FL_AW-1:0]  ifl_base,
  input  logic [RAM_AW-1:0] iram_base,
  input  logic [LEN_W-1:0]  ilen,
  input  logic              iswap,
  output logic              oloading,
  output logic              odone,
  output logic [LEN_W-1:0]  ocount,
  input  logic              irom_load_wait,
  output logic              orom_load_wr,
  output logic              oram_Wrl,
  output logic              oram_Wrh,
  output logic [RAM_AW-1:0] oram_addr,
  output logic [15:0]       oram_wrdata,
  output logic [FL_AW-1:0]  ofl_addr,
  input  logic [15:0]       ifl_data,
  output logic              ofl_req,
  input  logic              ifl_ack
`ifdef FLASH_SDRAM_LOADER_CSUM_EN
  ,
  output logic [15:0]       ocsum
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FL_REQ  = 3'd1,
    ST_FL_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_HOLD = 3'd4,
    ST_WR_WAIT = 3'd5,
    ST_NEXT    = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  localparam logic [FL_AW-1:0]  FL_ONE  = {{(FL_AW-1){1'b0}}, 1'b1};
  localparam logic [RAM_AW-1:0] RAM_ONE = {{(RAM_AW-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  function automatic logic [15:0] byteswap(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  state_t            state_r,    state_s;
  logic [FL_AW-1:0]  fl_addr_r,  fl_addr_s;
  logic [RAM_AW-1:0] ram_addr_r, ram_addr_s;
  logic [LEN_W-1:0]  len_r,      len_s;
  logic [LEN_W-1:0]  count_r,    count_s;
  logic [15:0]       wrdata_r,   wrdata_s;
  logic              swap_r,     swap_s;
  logic              wr_r,       wr_s;
  logic              loading_r,  loading_s;
  logic              done_r,     done_s;
  logic              be_r,       be_s;
  logic              req_r,      req_s;
  logic              auto_r,     auto_s;
  logic              start_s;
`ifdef FLASH_SDRAM_LOADER_CSUM_EN
  logic [15:0]       csum_r,     csum_s;
`endif

  // Next-state and next-output computation for the copy sequencer
  always_comb begin
    state_s    = state_r;
    fl_addr_s  = fl_addr_r;
    ram_addr_s = ram_addr_r;
    len_s      = len_r;
    count_s    = count_r;
    wrdata_s   = wrdata_r;
    swap_s     = swap_r;
    wr_s       = wr_r;
    loading_s  = loading_r;
    done_s     = done_r;
    be_s       = be_r;
    req_s      = req_r;
    auto_s     = auto_r;
`ifdef FLASH_SDRAM_LOADER_CSUM_EN
    csum_s     = csum_r;
`endif
    // auto_r is only ever set before the first copy leaves IDLE
    start_s    = istart | auto_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          auto_s     = 1'b0;
          fl_addr_s  = ifl_base;
          ram_addr_s = iram_base;
          len_s      = ilen;
          swap_s     = iswap;
          count_s    = {LEN_W{1'b0}};
`ifdef FLASH_SDRAM_LOADER_CSUM_EN
          csum_s     = 16'h0000;
`endif
          if (ilen == {LEN_W{1'b0}}) begin
            done_s    = 1'b1;
            loading_s = 1'b0;
            be_s      = 1'b0;
            state_s   = ST_DONE;
          end else begin
            done_s    = 1'b0;
            loading_s = 1'b1;
            be_s      = 1'b1;
            state_s   = ST_FL_REQ;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_FL_REQ: begin
        req_s   = ~ifl_ack;
        state_s = ST_FL_WAIT;
      end
      ST_FL_WAIT: begin
        if (ifl_ack == req_r) begin
          state_s = ST_WR;
        end else begin
          state_s = ST_FL_WAIT;
        end
      end
      ST_WR: begin
        wrdata_s = swap_r ? byteswap(ifl_data) : ifl_data;
        wr_s     = 1'b1;
        state_s  = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        // Guard cycle: the arbiter may not raise its wait flag until after the strobe
        wr_s    = 1'b0;
        state_s = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (!irom_load_wait) begin
          count_s = count_r + LEN_ONE;
`ifdef FLASH_SDRAM_LOADER_CSUM_EN
          csum_s  = csum_r + wrdata_r;
`endif
          state_s = ST_NEXT;
        end else begin
          state_s = ST_WR_WAIT;
        end
      end
      ST_NEXT: begin
        if (count_r == len_r) begin
          loading_s = 1'b0;
          be_s      = 1'b0;
          done_s    = 1'b1;
          state_s   = ST_DONE;
        end else begin
          fl_addr_s  = fl_addr_r + FL_ONE;
          ram_addr_s = ram_addr_r + RAM_ONE;
          state_s    = ST_FL_REQ;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any copy in flight
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_r    <= ST_IDLE;
      fl_addr_r  <= {FL_AW{1'b0}};
      ram_addr_r <= {RAM_AW{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      count_r    <= {LEN_W{1'b0}};
      wrdata_r   <= 16'h0000;
      swap_r     <= 1'b0;
      wr_r       <= 1'b0;
      loading_r  <= 1'b0;
      done_r     <= 1'b0;
      be_r       <= 1'b0;
      req_r      <= 1'b0;
      auto_r     <= AUTO_START;
`ifdef FLASH_SDRAM_LOADER_CSUM_EN
      csum_r     <= 16'h0000;
`endif
    end else begin
      state_r    <= state_s;
      fl_addr_r  <= fl_addr_s;
      ram_addr_r <= ram_addr_s;
      len_r      <= len_s;
      count_r    <= count_s;
      wrdata_r   <= wrdata_s;
      swap_r     <= swap_s;
      wr_r       <= wr_s;
      loading_r  <= loading_s;
      done_r     <= done_s;
      be_r       <= be_s;
      req_r      <= req_s;
      auto_r     <= auto_s;
`ifdef FLASH_SDRAM_LOADER_CSUM_EN
      csum_r     <= csum_s;
`endif
    end
  end

  assign oloading     = loading_r;
  assign odone        = done_r;
  assign ocount       = count_r;
  assign orom_load_wr = wr_r;
  assign oram_Wrl     = be_r;
  assign oram_Wrh     = be_r;
  assign oram_addr    = ram_addr_r;
  assign oram_wrdata  = wrdata_r;
  assign ofl_addr     = fl_addr_r;
  assign ofl_req      = req_r;
`ifdef FLASH_SDRAM_LOADER_CSUM_EN
  assign ocsum        = csum_r;
`endif

endmodule
